// File: rtl/par_frame_ctrl_pkg.sv
// Shared definitions for the zero-parity frame sequencer.
package par_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Frame sequencer states; 2'b11 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    REPORT = 2'b10
  } state_t;

endpackage

// File: rtl/par_frame_ctrl_bit_acc.sv
// Zero-count and adjacent-ones accumulator for the serial frame stream.
module par_bit_acc #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          bit_in,
  output logic [CW-1:0] zero_cnt,
  output logic          err
);

  logic prev;

  // Count zero bits and flag any 1 that follows a 1 within the frame.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      zero_cnt <= '0;
      err      <= 1'b0;
      prev     <= 1'b0;
    end else if (en) begin
      if (!bit_in) begin
        zero_cnt <= zero_cnt + CW'(1);
      end
      if (bit_in && prev) begin
        err <= 1'b1;
      end
      prev <= bit_in;
    end
  end

endmodule

// File: rtl/par_frame_ctrl.sv
// Frame sequencer: loads a word, shifts it out MSB-first and reports zero
// count, zero parity and adjacent-ones error with a one-cycle done pulse.
module par_frame_ctrl
  import par_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    zero_cnt,
  output logic             zero_par,
  output logic             err
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    idx;
  logic             load;
  logic             shifting;
  logic             last_bit;

  assign load     = (state == IDLE) && start;
  assign shifting = (state == SHIFT);
  assign last_bit = (idx == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start outside IDLE is ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register and bit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      idx   <= '0;
    end else if (load) begin
      shreg <= data_in;
      idx   <= '0;
    end else if (shifting) begin
      shreg <= shreg << 1;
      idx   <= idx + CW'(1);
    end
  end

  par_bit_acc #(
    .CW (CW)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .clr      (load),
    .en       (shifting),
    .bit_in   (shreg[WIDTH-1]),
    .zero_cnt (zero_cnt),
    .err      (err)
  );

  // Outputs decoded from state and registered datapath only.
  always_comb begin
    bit_out   = 1'b0;
    bit_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      SHIFT: begin
        bit_out   = shreg[WIDTH-1];
        bit_valid = 1'b1;
        busy      = 1'b1;
      end
      REPORT:  done = 1'b1;
      default: ;
    endcase
    zero_par = zero_cnt[0];
  end

endmodule

// File: tb/tb_par_frame_ctrl.sv
// Directed scoreboard bench for par_frame_ctrl (WIDTH = 8).
module tb_par_frame_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  data_in;
  logic          bit_out;
  logic          bit_valid;
  logic          busy;
  logic          done;
  logic [CW-1:0] zero_cnt;
  logic          zero_par;
  logic          err;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  typedef struct {
    logic [3:0]    ctl;     // {bit_out, bit_valid, busy, done}
    logic          chk_res;
    logic [CW-1:0] zc;
    logic          zp;
    logic          er;
  } exp_t;

  exp_t sb[$];

  // Result registers expected to hold between frames.
  logic [CW-1:0] held_zc = '0;
  logic          held_er = 1'b0;

  par_frame_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .busy      (busy),
    .done      (done),
    .zero_cnt  (zero_cnt),
    .zero_par  (zero_par),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] count_zeros(input logic [W-1:0] d);
    logic [CW-1:0] n = '0;
    for (int i = 0; i < W; i++) if (!d[i]) n = n + CW'(1);
    return n;
  endfunction

  function automatic logic has_adjacent_ones(input logic [W-1:0] d);
    logic r = 1'b0;
    for (int i = 0; i < W - 1; i++) if (d[i] && d[i+1]) r = 1'b1;
    return r;
  endfunction

  task automatic push(input logic [3:0] ctl, input logic chk,
                      input logic [CW-1:0] zc, input logic er);
    exp_t e;
    e.ctl = ctl; e.chk_res = chk; e.zc = zc; e.zp = zc[0]; e.er = er;
    sb.push_back(e);
  endtask

  // Expected output per cycle after the accepting edge: W shift bits,
  // one REPORT cycle and, if with_idle, the following IDLE cycle.
  task automatic push_frame(input logic [W-1:0] d, input bit with_idle);
    logic [CW-1:0] zc;
    logic er;
    zc = count_zeros(d);
    er = has_adjacent_ones(d);
    for (int i = W - 1; i >= 0; i--) push({d[i], 1'b1, 1'b1, 1'b0}, 1'b0, '0, 1'b0);
    push(4'b0001, 1'b1, zc, er);
    if (with_idle) push(4'b0000, 1'b1, zc, er);
    held_zc = zc;
    held_er = er;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag);
    exp_t e;
    vectors++;
    assert (sb.size() != 0) else begin
      miscompares++;
      $error("FAIL %s: scoreboard empty, observed ctl=%b", tag,
             {bit_out, bit_valid, busy, done});
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      assert ({bit_out, bit_valid, busy, done} === e.ctl) else begin
        miscompares++;
        $error("FAIL %s ctl{bo,bv,busy,done}: observed %b expected %b", tag,
               {bit_out, bit_valid, busy, done}, e.ctl);
      end
      if (e.chk_res) begin
        vectors++;
        assert ({zero_cnt, zero_par, err} === {e.zc, e.zp, e.er}) else begin
          miscompares++;
          $error("FAIL %s results{zc,zp,err}: observed %0d,%b,%b expected %0d,%b,%b",
                 tag, zero_cnt, zero_par, err, e.zc, e.zp, e.er);
        end
      end
    end
  endtask

  // Single frame with start pulsed on one edge only.
  task automatic run_frame(input logic [W-1:0] d, input string tag);
    start   = 1'b1;
    data_in = d;
    push_frame(d, 1'b1);
    tick();
    start   = 1'b0;
    data_in = ~d;
    check(tag);
    for (int i = 1; i < W + 2; i++) begin
      tick();
      check(tag);
    end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;

    // Reset state, with start asserted on the second reset edge.
    push(4'b0000, 1'b1, '0, 1'b0);
    push(4'b0000, 1'b1, '0, 1'b0);
    tick(); check("reset");
    start = 1'b1; data_in = 8'hFF;
    tick(); check("rst_beats_start");
    rst = 1'b0; start = 1'b0;
    push(4'b0000, 1'b1, '0, 1'b0);
    tick(); check("idle_after_reset");

    run_frame(8'hA5, "frame_A5");
    run_frame(8'hF0, "frame_F0");
    run_frame(8'h01, "frame_01");
    run_frame(8'h00, "frame_00");

    // Idle with start low: results hold.
    push(4'b0000, 1'b1, held_zc, held_er);
    push(4'b0000, 1'b1, held_zc, held_er);
    tick(); check("idle_hold");
    tick(); check("idle_hold");

    // start held high: second acceptance only W+2 edges after the first;
    // data_in is scrambled while SHIFT/REPORT are active.
    start   = 1'b1;
    data_in = 8'h5A;
    push_frame(8'h5A, 1'b0);
    push(4'b0000, 1'b1, held_zc, held_er);
    push_frame(8'h5A, 1'b1);
    for (int i = 0; i < W + 2; i++) begin
      tick();
      check("held_start_f1");
      data_in = (i < W) ? 8'hFF : 8'h5A;
    end
    for (int i = 0; i < W + 2; i++) begin
      tick();
      check("held_start_f2");
      if (i == 0) begin
        start   = 1'b0;
        data_in = 8'h3C;
      end
    end

    // Reset mid-frame: rst sampled at T+4 aborts without a done pulse.
    start   = 1'b1;
    data_in = 8'hA5;
    for (int i = W - 1; i >= W - 4; i--) begin
      logic [W-1:0] d;
      d = 8'hA5;
      push({d[i], 1'b1, 1'b1, 1'b0}, 1'b0, '0, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_shift");
      start = 1'b0;
    end
    rst = 1'b1;
    push(4'b0000, 1'b1, '0, 1'b0);
    tick(); check("abort_reset");
    rst = 1'b0;
    for (int i = 0; i < W + 2; i++) push(4'b0000, 1'b1, '0, 1'b0);
    for (int i = 0; i < W + 2; i++) begin
      tick();
      check("abort_no_done");
    end

    run_frame(8'hA5, "frame_after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary within time limit");
    $fatal(1, "timeout");
  end

endmodule
